// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined adder, one K=WIDTH/STAGES slice per stage.
// Ports: clk, rst_n, in_valid/in_ready, a, b, sub, cin in;
// out_valid/out_ready, s, cout out; flags {N,Z,C,V} with PIPE_ADDER_FLAGS_EN.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPE_ADDER_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int K = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;
  localparam int L = (STAGES >= 1) ? STAGES - 1 : 0;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_adder: STAGES must be >= 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic              rdy_q;
  logic              take;

  // A stage may advance if it or any later stage has a hole,
  // or the consumer drains the last stage this cycle.
  always_comb begin
    logic hole;
    adv  = '0;
    hole = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole   = hole | ~vld[i];
      adv[i] = hole;
    end
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign in_ready = rdy_q & adv[0];
  assign take     = in_valid & in_ready;

  for (genvar g = 0; g < STAGES; g++) begin : stg
    // Stage g sees HI unprocessed operand bits and
    // stores LO finished sum bits.
    localparam int HI = WIDTH - g * K;
    localparam int LO = (g + 1) * K;

    logic [HI-1:0] pa;
    logic [HI-1:0] pb;
    logic          pc;
    logic          pv;
    logic [K:0]    sl;
    logic [LO-1:0] s_d;
    logic [LO-1:0] s_q;
    logic          v_q;
    logic          c_q;

    if (g == 0) begin : src
      assign pa  = a;
      assign pb  = sub ? ~b : b;
      assign pc  = cin;
      assign pv  = take;
      assign s_d = sl[K-1:0];
    end else begin : src
      assign pa  = stg[g-1].op.a_q;
      assign pb  = stg[g-1].op.b_q;
      assign pc  = stg[g-1].c_q;
      assign pv  = stg[g-1].v_q;
      assign s_d = {sl[K-1:0], stg[g-1].s_q};
    end

    assign sl = {1'b0, pa[K-1:0]}
              + {1'b0, pb[K-1:0]}
              + {{K{1'b0}}, pc};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv[g]) begin
        v_q <= pv;
        c_q <= sl[K];
        s_q <= s_d;
      end
    end

    if (g < STAGES - 1) begin : op
      logic [HI-K-1:0] a_q;
      logic [HI-K-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[g]) begin
          a_q <= pa[HI-1:K];
          b_q <= pb[HI-1:K];
        end
      end
    end

    assign vld[g] = v_q;

`ifdef PIPE_ADDER_FLAGS_EN
    if (g == STAGES - 1) begin : fl
      logic [3:0] f_q;
      logic       ovf;

      // Same operand signs but result sign differs.
      assign ovf = (pa[K-1] == pb[K-1]) && (s_d[LO-1] != pa[K-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      f_q <= 4'b0;
        else if (adv[g]) f_q <= {s_d[LO-1], s_d == '0, sl[K], ovf};
      end
    end
`endif
  end

  assign out_valid = vld[L];
  assign s         = stg[L].s_q;
  assign cout      = stg[L].c_q;
`ifdef PIPE_ADDER_FLAGS_EN
  assign flags     = stg[L].fl.f_q;
`endif

endmodule
